// File: rtl/logo_cmd_parser.sv
// LOGO command-line parser: collects keyboard ASCII, parses on Enter (result at E+count+1), holds cmd_valid until cmd_ready.
// Characters are dropped while busy; define LOGO_CMD_BACKSPACE_EN to make 0x08 delete the last buffered character.
module logo_cmd_parser #(
  parameter int BUF_DEPTH = 8
) (
  input  logic        ps2_clock,
  input  logic        reset,
  input  logic        char_valid,
  input  logic [7:0]  char_data,
  input  logic        cmd_ready,
  output logic        cmd_valid,
  output logic [31:0] cmd_word,
  output logic        cmd_error,
  output logic        busy,
  output logic [3:0]  char_count
);

  localparam logic [3:0] DEPTH = 4'(BUF_DEPTH);

  typedef enum logic [1:0] {
    S_COLLECT,
    S_PARSE,
    S_VALID,
    S_ERR
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [15:0][7:0] r_buf;
  logic [3:0]       r_count;
  logic [3:0]       r_idx;
  logic             r_overflow;
  logic             r_bad;
  logic             r_motion;
  logic [7:0]       r_opcode;
  logic [15:0]      r_arg;
  logic             r_cmd_valid;
  logic [31:0]      r_cmd_word;

  logic        w_printable;
  logic        w_append;
  logic        w_drop_full;
  logic        w_backspace;
  logic        w_enter;
  logic        w_step;
  logic        w_clear;
  logic        w_line_ok;
  logic [7:0]  w_ch;
  logic        w_is_digit;
  logic [7:0]  w_lookup;
  logic        w_lookup_motion;
  logic [19:0] w_arg_wide;
  logic [15:0] w_arg_sat;

  assign w_printable = ((char_data >= 8'h41) && (char_data <= 8'h5A)) ||
                       ((char_data >= 8'h30) && (char_data <= 8'h39)) ||
                       (char_data == 8'h20);

  // Character currently being consumed by PARSE.
  assign w_ch       = r_buf[r_idx];
  assign w_is_digit = (w_ch >= 8'h30) && (w_ch <= 8'h39);

  always_comb begin
    w_lookup = 8'h00;
    case ({r_buf[0], r_buf[1]})
      "FD":    w_lookup = 8'h01;
      "BK":    w_lookup = 8'h02;
      "LT":    w_lookup = 8'h03;
      "RT":    w_lookup = 8'h04;
      "PU":    w_lookup = 8'h05;
      "PD":    w_lookup = 8'h06;
      "CS":    w_lookup = 8'h07;
      "HT":    w_lookup = 8'h08;
      default: w_lookup = 8'h00;
    endcase
  end

  assign w_lookup_motion = (w_lookup >= 8'h01) && (w_lookup <= 8'h04);

  // Once the argument exceeds 16 bits it stays pinned at all-ones.
  assign w_arg_wide = 20'(r_arg) * 20'd10 + 20'(w_ch[3:0]);
  assign w_arg_sat  = (w_arg_wide > 20'h0FFFF) ? 16'hFFFF : w_arg_wide[15:0];

  assign w_line_ok = !r_bad && !r_overflow && (r_opcode != 8'h00) &&
                     (r_motion ? (r_count >= 4'd4) : (r_count == 4'd2));

  always_ff @(posedge ps2_clock) begin
    if (reset) begin
      r_state <= S_COLLECT;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_append    = 1'b0;
    w_drop_full = 1'b0;
    w_backspace = 1'b0;
    w_enter     = 1'b0;
    w_step      = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      S_COLLECT: begin
        if (char_valid) begin
          if (w_printable) begin
            if (r_count < DEPTH) begin
              w_append = 1'b1;
            end else begin
              w_drop_full = 1'b1;
            end
          end else if (char_data == 8'h0D) begin
            if (r_count != 4'd0) begin
              w_enter = 1'b1;
              w_next  = S_PARSE;
            end
          end
`ifdef LOGO_CMD_BACKSPACE_EN
          else if (char_data == 8'h08) begin
            if (r_count != 4'd0) begin
              w_backspace = 1'b1;
            end
          end
`else
`endif
        end
      end
      S_PARSE: begin
        if (r_idx == r_count) begin
          w_next = w_line_ok ? S_VALID : S_ERR;
        end else begin
          w_step = 1'b1;
        end
      end
      S_VALID: begin
        if (cmd_ready) begin
          w_next  = S_COLLECT;
          w_clear = 1'b1;
        end
      end
      S_ERR: begin
        w_next  = S_COLLECT;
        w_clear = 1'b1;
      end
      default: begin
        w_next  = S_COLLECT;
        w_clear = 1'b1;
      end
    endcase
  end

  always_ff @(posedge ps2_clock) begin
    if (reset || w_clear) begin
      r_buf      <= '0;
      r_count    <= 4'd0;
      r_idx      <= 4'd0;
      r_overflow <= 1'b0;
      r_bad      <= 1'b0;
      r_motion   <= 1'b0;
      r_opcode   <= 8'h00;
      r_arg      <= 16'h0000;
    end else begin
      if (w_append) begin
        r_buf[r_count] <= char_data;
        r_count        <= r_count + 4'd1;
      end
      if (w_backspace) begin
        r_count <= r_count - 4'd1;
      end
      if (w_drop_full) begin
        r_overflow <= 1'b1;
      end
      if (w_enter) begin
        r_idx <= 4'd0;
      end
      // Char 0 needs no action: the mnemonic is judged once char 1 arrives.
      if (w_step) begin
        r_idx <= r_idx + 4'd1;
        if (r_idx == 4'd1) begin
          r_opcode <= w_lookup;
          r_motion <= w_lookup_motion;
        end else if (r_idx == 4'd2) begin
          if (r_motion && (w_ch != 8'h20)) begin
            r_bad <= 1'b1;
          end
        end else if ((r_idx >= 4'd3) && r_motion) begin
          if (!w_is_digit) begin
            r_bad <= 1'b1;
          end else begin
            r_arg <= w_arg_sat;
          end
        end
      end
    end
  end

  always_ff @(posedge ps2_clock) begin
    if (reset) begin
      r_cmd_valid <= 1'b0;
      r_cmd_word  <= 32'h0;
    end else if ((r_state == S_PARSE) && (w_next == S_VALID)) begin
      r_cmd_valid <= 1'b1;
      r_cmd_word  <= {r_opcode, 8'h00, r_arg};
    end else if ((r_state == S_VALID) && cmd_ready) begin
      r_cmd_valid <= 1'b0;
      r_cmd_word  <= 32'h0;
    end
  end

  assign cmd_valid  = r_cmd_valid;
  assign cmd_word   = r_cmd_word;
  assign cmd_error  = (r_state == S_ERR);
  assign busy       = (r_state == S_PARSE) || (r_state == S_VALID);
  assign char_count = r_count;

endmodule

// File: tb/tb_logo_cmd_parser.sv
`timescale 1ns/1ps
// Drives directed and random command lines; a line-level model predicts each result into a queue
// that an independent monitor drains whenever cmd_valid rises or cmd_error pulses.
module tb_logo_cmd_parser;
  localparam int DEPTH = 8;

  logic        ps2_clock = 1'b0;
  logic        reset = 1'b1;
  logic        char_valid = 1'b0;
  logic [7:0]  char_data = 8'h00;
  logic        cmd_ready = 1'b0;
  logic        cmd_valid;
  logic [31:0] cmd_word;
  logic        cmd_error;
  logic        busy;
  logic [3:0]  char_count;

  logo_cmd_parser #(.BUF_DEPTH(DEPTH)) dut (
    .ps2_clock (ps2_clock),
    .reset     (reset),
    .char_valid(char_valid),
    .char_data (char_data),
    .cmd_ready (cmd_ready),
    .cmd_valid (cmd_valid),
    .cmd_word  (cmd_word),
    .cmd_error (cmd_error),
    .busy      (busy),
    .char_count(char_count)
  );

  always #5 ps2_clock = ~ps2_clock;

  int cyc = 0;
  always @(posedge ps2_clock) cyc <= cyc + 1;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
  endtask

  typedef struct {
    bit          err;
    logic [31:0] word;
    int          t_out;
    int          t_rel;
  } exp_t;
  exp_t exp_q[$];

  // Line model: buffered characters plus the sticky overflow flag.
  byte unsigned line[$];
  bit           ovf = 1'b0;
  byte unsigned tx[$];
  string        mns[8] = '{"FD", "BK", "LT", "RT", "PU", "PD", "CS", "HT"};

  function automatic bit is_print(input byte unsigned b);
    return ((b >= 8'h41) && (b <= 8'h5A)) || ((b >= 8'h30) && (b <= 8'h39)) || (b == 8'h20);
  endfunction

  function automatic void model_char(input byte unsigned b);
    if (is_print(b)) begin
      if (line.size() < DEPTH) line.push_back(b);
      else ovf = 1'b1;
    end
`ifdef LOGO_CMD_BACKSPACE_EN
    else if ((b == 8'h08) && (line.size() > 0)) begin
      void'(line.pop_back());
    end
`endif
  endfunction

  function automatic void model_eval(output bit err, output logic [31:0] word);
    string mn;
    int    op, arg, n, d;
    bit    motion, ok;
    n   = line.size();
    op  = 0;
    arg = 0;
    mn  = (n >= 2) ? $sformatf("%c%c", line[0], line[1]) : "";
    case (mn)
      "FD": op = 1;
      "BK": op = 2;
      "LT": op = 3;
      "RT": op = 4;
      "PU": op = 5;
      "PD": op = 6;
      "CS": op = 7;
      "HT": op = 8;
      default: op = 0;
    endcase
    motion = (op >= 1) && (op <= 4);
    ok = !ovf && (op != 0);
    if (motion) begin
      if (n < 4) ok = 1'b0;
      else if (line[2] != 8'h20) ok = 1'b0;
      for (int i = 3; i < n; i++) begin
        d = int'(line[i]) - 48;
        if ((d < 0) || (d > 9)) ok = 1'b0;
        else arg = (arg * 10 + d > 65535) ? 65535 : arg * 10 + d;
      end
    end else if (n != 2) begin
      ok = 1'b0;
    end
    err  = !ok;
    word = ok ? {op[7:0], 8'h00, arg[15:0]} : 32'h0;
  endfunction

  function automatic byte unsigned rand_print();
    int r;
    r = int'($urandom_range(0, 36));
    if (r < 26) return 8'(8'h41 + r);
    if (r < 36) return 8'(8'h30 + r - 26);
    return 8'h20;
  endfunction

  function automatic byte unsigned rand_noise();
    byte unsigned b;
    if ($urandom_range(0, 1) == 1) return 8'h08;
    b = 8'($urandom_range(0, 255));
    return (b == 8'h0D) ? 8'h2E : b;
  endfunction

  task automatic send_byte(input byte unsigned b);
    @(negedge ps2_clock);
    chk("char_count", 32'(char_count), 32'(line.size()));
    chk("busy_idle", 32'(busy), 32'd0);
    char_valid = 1'b1;
    char_data  = b;
    cmd_ready  = 1'($urandom_range(0, 1));
    model_char(b);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge ps2_clock);
      char_valid = 1'b0;
      cmd_ready  = 1'($urandom_range(0, 1));
    end
  endtask

  // Enter, then drive junk and cmd_ready through the busy window; release edge = E+n+2+hold.
  task automatic send_enter(input int hold, input bit junk);
    bit          err;
    logic [31:0] w;
    int          n, e, rel;
    exp_t        x;
    @(negedge ps2_clock);
    chk("count_at_enter", 32'(char_count), 32'(line.size()));
    char_valid = 1'b1;
    char_data  = 8'h0D;
    cmd_ready  = 1'($urandom_range(0, 1));
    n = line.size();
    if (n == 0) return;
    e = cyc + 1;
    model_eval(err, w);
    rel = err ? e + n + 2 : e + n + 2 + hold;
    x.err = err; x.word = w; x.t_out = e + n + 1; x.t_rel = rel;
    exp_q.push_back(x);
    line.delete();
    ovf = 1'b0;
    for (int k = e; k < rel; k++) begin
      @(negedge ps2_clock);
      chk("busy", 32'(busy), 32'((k <= e + n) || !err));
      char_valid = junk && (k + 1 <= (err ? e + n + 1 : rel)) && ($urandom_range(0, 1) == 1);
      char_data  = 8'($urandom_range(0, 255));
      if (err || (k + 1 <= e + n + 1)) cmd_ready = 1'($urandom_range(0, 1));
      else cmd_ready = (k + 1 == rel);
    end
  endtask

  task automatic send_tx(input int hold, input bit junk);
    foreach (tx[i]) begin
      send_byte(tx[i]);
      if ($urandom_range(0, 4) == 0) idle(int'($urandom_range(1, 2)));
    end
    send_enter(hold, junk);
  endtask

  task automatic set_tx(input string s);
    tx.delete();
    for (int i = 0; i < s.len(); i++) tx.push_back(s[i]);
  endtask

  task automatic rand_line();
    string m;
    int    kind;
    tx.delete();
    kind = int'($urandom_range(0, 5));
    case (kind)
      0, 1: begin
        m = mns[$urandom_range(0, 3)];
        tx.push_back(m[0]); tx.push_back(m[1]); tx.push_back(8'h20);
        repeat ($urandom_range(1, 5)) tx.push_back(8'(8'h30 + $urandom_range(0, 9)));
      end
      2: begin
        m = mns[$urandom_range(4, 7)];
        tx.push_back(m[0]); tx.push_back(m[1]);
      end
      3: repeat ($urandom_range(1, DEPTH + 3)) tx.push_back(rand_print());
      4: begin
        m = mns[$urandom_range(0, 7)];
        tx.push_back(m[0]); tx.push_back(rand_noise()); tx.push_back(m[1]);
        tx.push_back(8'h20);
        repeat ($urandom_range(1, 4)) begin
          tx.push_back(8'(8'h30 + $urandom_range(0, 9)));
          if ($urandom_range(0, 2) == 0) tx.push_back(rand_noise());
        end
      end
      default: begin
        m = mns[$urandom_range(0, 7)];
        tx.push_back(m[0]);
        if ($urandom_range(0, 1) == 1) tx.push_back(m[1]);
        if ($urandom_range(0, 1) == 1) tx.push_back(8'h20);
        repeat ($urandom_range(0, 3)) tx.push_back(rand_print());
      end
    endcase
  endtask

  // Monitor: independent of the driver, consumes one expectation per output event.
  exp_t cur;
  bit   have_cur = 1'b0;
  bit   prev_v = 1'b0;
  bit   prev_e = 1'b0;
  initial begin
    forever begin
      @(negedge ps2_clock);
      if (reset) begin
        prev_v = 1'b0; prev_e = 1'b0; have_cur = 1'b0;
      end else begin
        if (cmd_valid && !prev_v) begin
          if (exp_q.size() == 0) chk("unexpected_valid", 32'(cmd_valid), 32'd0);
          else begin
            cur = exp_q.pop_front();
            have_cur = 1'b1;
            chk("valid_kind", 32'(cur.err), 32'd0);
            chk("valid_time", 32'(cyc), 32'(cur.t_out));
          end
        end
        if (cmd_valid && have_cur) chk("cmd_word", cmd_word, cur.word);
        if (!cmd_valid && prev_v && have_cur) begin
          chk("release_time", 32'(cyc), 32'(cur.t_rel));
          have_cur = 1'b0;
        end
        if (prev_e) chk("error_width", 32'(cmd_error), 32'd0);
        else if (cmd_error) begin
          if (exp_q.size() == 0) chk("unexpected_error", 32'(cmd_error), 32'd0);
          else begin
            cur = exp_q.pop_front();
            chk("error_kind", 32'(cur.err), 32'd1);
            chk("error_time", 32'(cyc), 32'(cur.t_out));
          end
        end
        prev_v = cmd_valid;
        prev_e = cmd_error;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge ps2_clock);
    chk("rst_valid", 32'(cmd_valid), 32'd0);
    chk("rst_word", cmd_word, 32'h0);
    chk("rst_error", 32'(cmd_error), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(char_count), 32'd0);
    reset = 1'b0;

    set_tx("FD 100");  send_tx(0, 1'b0);
    set_tx("PU");      send_tx(0, 1'b0);
    set_tx("FD");      send_tx(0, 1'b0);
    tx.delete();
    tx = '{8'h52, 8'h58, 8'h08, 8'h54, 8'h20, 8'h39, 8'h08, 8'h35};
    send_tx(0, 1'b0);
    set_tx("FD 123456"); send_tx(0, 1'b0);
    set_tx("LT 90");     send_tx(0, 1'b0);
    set_tx("RT 45");     send_tx(5, 1'b1);
    set_tx("FD 99999");  send_tx(1, 1'b0);
    send_enter(0, 1'b0);

    // Reset two edges into PARSE of a six-character line.
    set_tx("FD 100");
    foreach (tx[i]) send_byte(tx[i]);
    @(negedge ps2_clock);
    char_valid = 1'b1; char_data = 8'h0D;
    @(negedge ps2_clock);
    char_valid = 1'b0;
    @(negedge ps2_clock);
    reset = 1'b1;
    @(negedge ps2_clock);
    chk("midparse_rst_valid", 32'(cmd_valid), 32'd0);
    chk("midparse_rst_word", cmd_word, 32'h0);
    chk("midparse_rst_error", 32'(cmd_error), 32'd0);
    chk("midparse_rst_busy", 32'(busy), 32'd0);
    chk("midparse_rst_count", 32'(char_count), 32'd0);
    reset = 1'b0;
    line.delete(); ovf = 1'b0;
    set_tx("CS"); send_tx(0, 1'b0);

    for (int i = 0; i < 200; i++) begin
      rand_line();
      send_tx(int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 7) == 0) send_enter(0, 1'b0);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end

    idle(6);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
